// File: rtl/rv32_mod_instruction_align_if.sv
// rtl/rv32_mod_instruction_align_if.sv - fetch, decode and redirect signals of the instruction aligner
interface rv32_mod_instruction_align_if;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_instruction;
    logic        fetch_valid;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic        id_compressed;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output fetch_addr,
        input  fetch_instruction,
        input  fetch_valid,
        output id_valid,
        input  id_ready,
        output id_instruction,
        output id_pc,
        output id_compressed,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  fetch_addr,
        output fetch_instruction,
        output fetch_valid,
        input  id_valid,
        output id_ready,
        input  id_instruction,
        input  id_pc,
        input  id_compressed,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/rv32_mod_instruction_align.sv
// rtl/rv32_mod_instruction_align.sv - splits fetch words into 16/32-bit instructions with PC generation
module rv32_mod_instruction_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                               clk,
    input  logic                               reset,
    rv32_mod_instruction_align_if.master       bus
);

    localparam logic [31:0] RESET_WORD = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] RESET_HPC  = {RESET_PC[31:1], 1'b0};
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic [15:0] q_q [4];
    logic [15:0] q_d [4];
    logic [15:0] shifted [4];
    logic [2:0]  count_q, count_d;
    logic [2:0]  cnt_mid;
    logic [31:0] exp_addr_q, exp_addr_d;
    logic [31:0] req_addr_q;
    logic        skip_lo_q, skip_lo_d;
    logic [31:0] head_pc_q, head_pc_d;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_comp_q, id_comp_d;

    logic        consume;
    logic        take1;
    logic        take2;
    logic [1:0]  pop_n;
    logic        push;
    logic [31:0] fetch_addr;
    logic [31:0] redirect_word;
    logic [31:0] redirect_hpc;
    logic [15:0] word_lo;
    logic [15:0] word_hi;
    logic        unused_redirect_bit;

    assign unused_redirect_bit = bus.redirect_pc[0];
    assign word_lo       = bus.fetch_instruction[15:0];
    assign word_hi       = bus.fetch_instruction[31:16];
    assign redirect_word = {bus.redirect_pc[31:2], 2'b00};
    assign redirect_hpc  = {bus.redirect_pc[31:1], 1'b0};

    // Extraction decision and response acceptance, both from the pre-pop queue state.
    always_comb begin
        consume = !id_valid_q || bus.id_ready;
        take1   = (count_q != 3'd0) && (q_q[0][1:0] != 2'b11);
        take2   = (count_q >= 3'd2) && (q_q[0][1:0] == 2'b11);
        pop_n   = 2'd0;
        if (consume) begin
            if (take1) begin
                pop_n = 2'd1;
            end else if (take2) begin
                pop_n = 2'd2;
            end
        end
        // Held off during reset so the address seen by the fetch unit matches req_addr_q at release.
        push = !reset && bus.fetch_valid && (req_addr_q == exp_addr_q)
            && (count_q <= 3'd2) && !bus.redirect_valid;
        if (bus.redirect_valid) begin
            fetch_addr = redirect_word;
        end else if (push) begin
            fetch_addr = exp_addr_q + 32'd4;
        end else begin
            fetch_addr = exp_addr_q;
        end
    end

    // Queue update: pop first, then append behind what remains.
    always_comb begin
        case (pop_n)
            2'd1:    shifted = '{q_q[1], q_q[2], q_q[3], 16'h0000};
            2'd2:    shifted = '{q_q[2], q_q[3], 16'h0000, 16'h0000};
            default: shifted = q_q;
        endcase
        cnt_mid = count_q - {1'b0, pop_n};
        q_d     = shifted;
        count_d = cnt_mid;
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                if (skip_lo_q && (3'(i) == cnt_mid)) begin
                    q_d[i] = word_hi;
                end else if (!skip_lo_q && (3'(i) == cnt_mid)) begin
                    q_d[i] = word_lo;
                end else if (!skip_lo_q && (3'(i) == cnt_mid + 3'd1)) begin
                    q_d[i] = word_hi;
                end
            end
            count_d = skip_lo_q ? cnt_mid + 3'd1 : cnt_mid + 3'd2;
        end
        if (bus.redirect_valid) begin
            count_d = 3'd0;
        end
    end

    // Output registers, PC tracking and redirect handling.
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_comp_d  = id_comp_q;
        head_pc_d  = head_pc_q;
        exp_addr_d = exp_addr_q;
        skip_lo_d  = skip_lo_q;

        if (consume) begin
            if (take1) begin
                id_valid_d = 1'b1;
                id_instr_d = {16'h0000, q_q[0]};
                id_pc_d    = head_pc_q;
                id_comp_d  = 1'b1;
                head_pc_d  = head_pc_q + 32'd2;
            end else if (take2) begin
                id_valid_d = 1'b1;
                id_instr_d = {q_q[1], q_q[0]};
                id_pc_d    = head_pc_q;
                id_comp_d  = 1'b0;
                head_pc_d  = head_pc_q + 32'd4;
            end else begin
                id_valid_d = 1'b0;
            end
        end

        if (push) begin
            exp_addr_d = exp_addr_q + 32'd4;
            skip_lo_d  = 1'b0;
        end

        if (bus.redirect_valid) begin
            id_valid_d = 1'b0;
            exp_addr_d = redirect_word;
            head_pc_d  = redirect_hpc;
            skip_lo_d  = bus.redirect_pc[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                q_q[i] <= 16'h0000;
            end
            count_q    <= 3'd0;
            exp_addr_q <= RESET_WORD;
            req_addr_q <= RESET_WORD;
            skip_lo_q  <= RESET_PC[1];
            head_pc_q  <= RESET_HPC;
            id_valid_q <= 1'b0;
            id_instr_q <= NOP;
            id_pc_q    <= 32'h0000_0000;
            id_comp_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                q_q[i] <= q_d[i];
            end
            count_q    <= count_d;
            exp_addr_q <= exp_addr_d;
            req_addr_q <= fetch_addr;
            skip_lo_q  <= skip_lo_d;
            head_pc_q  <= head_pc_d;
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_comp_q  <= id_comp_d;
        end
    end

    assign bus.fetch_addr     = fetch_addr;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_instruction = id_instr_q;
    assign bus.id_pc          = id_pc_q;
    assign bus.id_compressed  = id_comp_q;

endmodule

// File: tb/tb_rv32_mod_instruction_align.sv
// tb/tb_rv32_mod_instruction_align.sv - scoreboard bench for rv32_mod_instruction_align
module tb_rv32_mod_instruction_align;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        c;
    } exp_t;

    logic clk;
    logic reset;
    rv32_mod_instruction_align_if bus ();

    rv32_mod_instruction_align #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [256];
    exp_t        sb_q [$];
    int          n_chk;
    int          n_err;
    int          n_out;
    logic        rnd_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.fetch_instruction <= mem[bus.fetch_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic gen_stream(input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [15:0] h0;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            h0   = hw(pc);
            e.pc = pc;
            if (h0[1:0] != 2'b11) begin
                e.ins = {16'h0000, h0};
                e.c   = 1'b1;
                pc    = pc + 32'd2;
            end else begin
                e.ins = {hw(pc + 32'd2), h0};
                e.c   = 1'b0;
                pc    = pc + 32'd4;
            end
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.id_valid && bus.id_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("id_pc", bus.id_pc, e.pc);
                    chk("id_instruction", bus.id_instruction, e.ins);
                    chk("id_compressed", {31'h0, bus.id_compressed}, {31'h0, e.c});
                end
                n_out++;
            end
            if (bus.redirect_valid) begin
                sb_q.delete();
                gen_stream({bus.redirect_pc[31:1], 1'b0}, 256);
            end
        end
    end

    task automatic fill_mem(input int ph);
        for (int i = 0; i < 256; i++) begin
            mem[i] = (ph == 2) ? $urandom : (32'h0000_0013 | (32'(i) << 7));
        end
        case (ph)
            2: mem[8'h40] = 32'h4501_4505;
            3: begin
                mem[8'h40] = 32'h0093_4505;
                mem[8'h41] = 32'h4505_0000;
            end
            4: mem[8'h80] = 32'h4585_0013;
            default: ;
        endcase
    endtask

    task automatic start_phase(input int ph);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_id_valid", {31'h0, bus.id_valid}, 32'd0);
        chk("rst_id_instruction", bus.id_instruction, 32'h0000_0013);
        chk("rst_id_pc", bus.id_pc, 32'd0);
        chk("rst_id_compressed", {31'h0, bus.id_compressed}, 32'd0);
        chk("rst_fetch_addr", bus.fetch_addr, 32'h0000_0100);
        fill_mem(ph);
        sb_q.delete();
        gen_stream(32'h0000_0100, 256);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget);
        int start;
        int k;
        start = n_out;
        k     = 0;
        while ((n_out - start < n) && (k < budget)) begin
            @(posedge clk);
            #1;
            if (rnd_ready) bus.id_ready = ($urandom_range(3) != 0);
            k++;
        end
        chk("progress", 32'(n_out - start >= n), 32'd1);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_ins;
        logic [31:0] prev_fa;
        n_chk = 0;
        n_err = 0;
        n_out = 0;
        rnd_ready          = 1'b0;
        reset              = 1'b1;
        bus.fetch_valid    = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Sequential 32-bit stream: fetch addresses and first-output latency.
        start_phase(1);
        @(negedge clk);
        chk("fa_c1", bus.fetch_addr, 32'h0000_0104);
        chk("idv_c1", {31'h0, bus.id_valid}, 32'd0);
        @(negedge clk);
        chk("fa_c2", bus.fetch_addr, 32'h0000_0108);
        chk("idv_c2", {31'h0, bus.id_valid}, 32'd0);
        @(negedge clk);
        chk("fa_c3", bus.fetch_addr, 32'h0000_010C);
        chk("idv_c3", {31'h0, bus.id_valid}, 32'd1);
        chk("first_pc", bus.id_pc, 32'h0000_0100);
        wait_outs(10, 100);

        // Decode stall: outputs held, fetch address repeats.
        @(posedge clk);
        #1;
        bus.id_ready = 1'b0;
        @(negedge clk);
        chk("stall_valid", {31'h0, bus.id_valid}, 32'd1);
        held_pc  = bus.id_pc;
        held_ins = bus.id_instruction;
        prev_fa  = bus.fetch_addr;
        for (int s = 1; s < 6; s++) begin
            @(negedge clk);
            chk("stall_pc", bus.id_pc, held_pc);
            chk("stall_ins", bus.id_instruction, held_ins);
            chk("stall_fa", bus.fetch_addr, prev_fa);
        end
        @(posedge clk);
        #1;
        bus.id_ready = 1'b1;
        wait_outs(10, 100);

        // Fetch gap: address constant, queue drains.
        @(posedge clk);
        #1;
        bus.fetch_valid = 1'b0;
        @(negedge clk);
        prev_fa = bus.fetch_addr;
        @(negedge clk);
        chk("gap_fa1", bus.fetch_addr, prev_fa);
        @(negedge clk);
        chk("gap_fa2", bus.fetch_addr, prev_fa);
        chk("gap_idv", {31'h0, bus.id_valid}, 32'd0);
        @(posedge clk);
        #1;
        bus.fetch_valid = 1'b1;
        wait_outs(10, 100);

        // Random compressed/32-bit mix with random decode backpressure.
        start_phase(2);
        rnd_ready = 1'b1;
        wait_outs(60, 800);
        rnd_ready = 1'b0;
        bus.id_ready = 1'b1;

        // 32-bit instruction straddling two words.
        start_phase(3);
        wait_outs(20, 200);

        // Redirects, including one with bit 0 set that wraps past the top of memory.
        start_phase(4);
        wait_outs(8, 100);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0202;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_flush", {31'h0, bus.id_valid}, 32'd0);
        wait_outs(10, 100);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        wait_outs(10, 100);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
